// File: rtl/pipe_mult_unit_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mult_unit_if
// Purpose  : Operand/result handshake bundle for the pipelined multiplier.
// Revision : 1.0
// ============================================================================
interface pipe_mult_unit_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic             in_signed;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  // Producer/consumer side: drives operands and result acceptance.
  modport master (
    output in_valid, in_signed, a, b, out_ready,
    input  in_ready, out_valid, hi, lo
  );

  // Multiplier side.
  modport slave (
    input  in_valid, in_signed, a, b, out_ready,
    output in_ready, out_valid, hi, lo
  );
endinterface
`default_nettype wire

// File: rtl/pipe_mult_unit.sv
`default_nettype none
// ============================================================================
// Module   : pipe_mult_unit
// Purpose  : Fully pipelined WIDTH x WIDTH MULT/MULTU unit, {hi, lo} result,
//            valid/ready backpressure. Optional pipeline kill: MULT_FLUSH_EN.
// Revision : 1.0
// ============================================================================
module pipe_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst,
`ifdef MULT_FLUSH_EN
  input  logic            flush,
`endif
  pipe_mult_unit_if.slave bus
);

  localparam int LEVELS  = $clog2(WIDTH);
  // Partial products plus every adder-tree node, stored level after level.
  localparam int c_nodes = 2 * WIDTH - 1;

  logic                              w_adv;
  logic                              w_a_neg;
  logic                              w_b_neg;
  logic                              w_sign;
  logic [WIDTH-1:0]                  w_a_mag;
  logic [WIDTH-1:0]                  w_b_mag;
  logic [2*WIDTH-1:0]                w_a_ext;
  logic [c_nodes-1:0][2*WIDTH-1:0]   w_next;
  logic [c_nodes-1:0][2*WIDTH-1:0]   r_tree;
  logic [LEVELS:0]                   r_valid;
  logic [LEVELS-1:0]                 r_sign;

  assign w_adv         = ~r_valid[LEVELS] | bus.out_ready;
  assign bus.in_ready  = w_adv;
  assign bus.out_valid = r_valid[LEVELS];
  assign bus.hi        = r_tree[c_nodes-1][2*WIDTH-1:WIDTH];
  assign bus.lo        = r_tree[c_nodes-1][WIDTH-1:0];

  // Negating the most negative value yields 2^(WIDTH-1), which is the
  // correct unsigned magnitude.
  assign w_a_neg = bus.in_signed & bus.a[WIDTH-1];
  assign w_b_neg = bus.in_signed & bus.b[WIDTH-1];
  assign w_sign  = w_a_neg ^ w_b_neg;
  assign w_a_mag = w_a_neg ? -bus.a : bus.a;
  assign w_b_mag = w_b_neg ? -bus.b : bus.b;
  assign w_a_ext = {{WIDTH{1'b0}}, w_a_mag};

  generate
    for (genvar i = 0; i < WIDTH; i++) begin : g_pp
      assign w_next[i] = w_b_mag[i] ? (w_a_ext << i) : '0;
    end

    for (genvar k = 1; k <= LEVELS; k++) begin : g_level
      localparam int c_src_base = 2 * WIDTH - 2 * (WIDTH >> (k - 1));
      localparam int c_dst_base = 2 * WIDTH - 2 * (WIDTH >> k);
      for (genvar j = 0; j < (WIDTH >> k); j++) begin : g_term
        logic [2*WIDTH-1:0] w_sum;
        assign w_sum = r_tree[c_src_base + 2*j] + r_tree[c_src_base + 2*j + 1];
        if (k == LEVELS) begin : g_final
          assign w_next[c_dst_base + j] = r_sign[LEVELS-1] ? -w_sum : w_sum;
        end else begin : g_add
          assign w_next[c_dst_base + j] = w_sum;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid <= '0;
      r_sign  <= '0;
      r_tree  <= '0;
    end else begin
      if (w_adv) begin
        r_valid <= {r_valid[LEVELS-1:0], bus.in_valid};
        r_sign  <= {r_sign[LEVELS-2:0], w_sign};
        r_tree  <= w_next;
      end
`ifdef MULT_FLUSH_EN
      // Kill wins over both advance and stall; data is left as-is.
      if (flush) begin
        r_valid <= '0;
      end
`endif
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_mult_unit.sv
`default_nettype none
// Self-checking bench for pipe_mult_unit: directed corners, streaming,
// backpressure, random traffic against a plain-arithmetic product model.
module tb_pipe_mult_unit;

`ifdef MULT_FLUSH_EN
  localparam int W = 8;
`else
  localparam int W = 32;
`endif
  localparam int LAT = $clog2(W) + 1;
  localparam logic [W-1:0] C_ONES = '1;
  localparam logic [W-1:0] C_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] C_MIN  = {1'b1, {(W-1){1'b0}}};

  logic clk = 1'b0;
  logic rst;
`ifdef MULT_FLUSH_EN
  logic flush;
`endif
  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];

  pipe_mult_unit_if #(.WIDTH(W)) bus ();

  pipe_mult_unit #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
`ifdef MULT_FLUSH_EN
    .flush (flush),
`endif
    .bus   (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [2*W-1:0] model(input logic s, input logic [W-1:0] x,
                                           input logic [W-1:0] y);
    logic signed [2*W-1:0] sx;
    logic signed [2*W-1:0] sy;
    if (s) begin
      sx = signed'({{W{x[W-1]}}, x});
      sy = signed'({{W{y[W-1]}}, y});
      return sx * sy;
    end
    return {{W{1'b0}}, x} * {{W{1'b0}}, y};
  endfunction

  function automatic logic [W-1:0] rand_op();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return C_ONES;
      2:       return C_MIN;
      3:       return C_ONE;
      default: return W'($urandom());
    endcase
  endfunction

  // One clock: drive at posedge+1, sample at negedge, return after next posedge+1.
  task automatic drive_cycle(input logic v, input logic s, input logic [W-1:0] x,
                             input logic [W-1:0] y, input logic ordy,
                             output logic acc, output logic ov,
                             output logic [2*W-1:0] res, output logic ir);
    bus.in_valid  = v;
    bus.in_signed = s;
    bus.a         = x;
    bus.b         = y;
    bus.out_ready = ordy;
    @(negedge clk);
    ir  = bus.in_ready;
    ov  = bus.out_valid;
    res = {bus.hi, bus.lo};
    acc = v & ir;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if (bus.hi !== '0) begin errors++; $display("FAIL reset_hi: got %h expected 0", bus.hi); end
    checks++;
    if (bus.lo !== '0) begin errors++; $display("FAIL reset_lo: got %h expected 0", bus.lo); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic test_directed();
    logic           cs[4];
    logic [W-1:0]   ca[4];
    logic [W-1:0]   cb[4];
    logic [2*W-1:0] ce[4];
    logic [W-1:0]   seven;
    logic acc, ov, ir, found;
    logic [2*W-1:0] res, got;
    int lat;
    seven = W'(7);
    cs[0] = 1'b0; ca[0] = C_ONES; cb[0] = C_ONES; ce[0] = {C_ONES - C_ONE, C_ONE};
    cs[1] = 1'b1; ca[1] = C_ONES; cb[1] = seven;  ce[1] = {C_ONES, -seven};
    cs[2] = 1'b1; ca[2] = C_MIN;  cb[2] = C_MIN;  ce[2] = {C_MIN >> 1, {W{1'b0}}};
    cs[3] = 1'b1; ca[3] = '0;     cb[3] = -seven; ce[3] = '0;
    for (int c = 0; c < 4; c++) begin
      drive_cycle(1'b1, cs[c], ca[c], cb[c], 1'b1, acc, ov, res, ir);
      checks++;
      if (acc !== 1'b1) begin errors++; $display("FAIL directed_accept[%0d]: got %b expected 1", c, acc); end
      found = 1'b0;
      lat   = 0;
      got   = '0;
      for (int n = 1; n <= 20 && !found; n++) begin
        drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, ov, res, ir);
        if (ov) begin found = 1'b1; lat = n; got = res; end
      end
      checks++;
      if (!found) begin
        errors++; $display("FAIL directed_timeout[%0d]: got no out_valid expected one within 20 cycles", c);
      end else begin
        checks++;
        if (lat !== LAT) begin errors++; $display("FAIL directed_latency[%0d]: got %0d expected %0d", c, lat, LAT); end
        checks++;
        if (got !== ce[c]) begin errors++; $display("FAIL directed_value[%0d]: got %h expected %h", c, got, ce[c]); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic acc, ov, ir, v, s;
    logic [W-1:0] x, y;
    logic [2*W-1:0] res, e;
    int k = 0;
    exp_q.delete();
    for (int t = 0; t < 40 && k < 8; t++) begin
      v = (t < 8);
      s = t[0];
      x = W'(t + 1);
      y = W'(3);
      drive_cycle(v, s, x, y, 1'b1, acc, ov, res, ir);
      if (v) begin
        checks++;
        if (ir !== 1'b1) begin errors++; $display("FAIL b2b_in_ready[%0d]: got %b expected 1", t, ir); end
      end
      if (acc) exp_q.push_back(model(s, x, y));
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL b2b_extra: got result %h expected none", res);
        end else begin
          e = exp_q.pop_front();
          if (res !== e) begin errors++; $display("FAIL b2b_value[%0d]: got %h expected %h", k, res, e); end
        end
        checks++;
        if (t !== LAT + k) begin errors++; $display("FAIL b2b_cycle[%0d]: got %0d expected %0d", k, t, LAT + k); end
        k++;
      end
    end
    checks++;
    if (k !== 8) begin errors++; $display("FAIL b2b_count: got %0d expected 8", k); end
  endtask

  task automatic test_backpressure();
    localparam int N = 12;
    logic acc, ov, ir, ordy, s;
    logic [W-1:0] x, y;
    logic [2*W-1:0] res, frozen;
    int issued = 0, recv = 0, stall = 0;
    exp_q.delete();
    frozen = '0;
    s = 1'($urandom()); x = rand_op(); y = rand_op();
    for (int t = 0; t < 80 && recv < N; t++) begin
      ordy = (stall >= 4);
      drive_cycle(issued < N, s, x, y, ordy, acc, ov, res, ir);
      if (acc) begin
        exp_q.push_back(model(s, x, y));
        issued++;
        s = 1'($urandom()); x = rand_op(); y = rand_op();
      end
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL bp_extra: got result %h expected none", res);
        end else if (res !== exp_q[0]) begin
          errors++; $display("FAIL bp_value: got %h expected %h", res, exp_q[0]);
        end
        if (!ordy) begin
          stall++;
          checks++;
          if (ir !== 1'b0) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b expected 0", stall, ir); end
          if (stall == 1) frozen = res;
          else begin
            checks++;
            if (res !== frozen) begin errors++; $display("FAIL bp_frozen[%0d]: got %h expected %h", stall, res, frozen); end
          end
        end else if (exp_q.size() != 0) begin
          void'(exp_q.pop_front());
          recv++;
        end
      end
    end
    checks++;
    if (recv !== N) begin errors++; $display("FAIL bp_count: got %0d expected %0d", recv, N); end
    checks++;
    if (stall !== 4) begin errors++; $display("FAIL bp_stall_cycles: got %0d expected 4", stall); end
  endtask

  task automatic test_random();
    localparam int NR = 150;
    logic acc, ov, ir, ordy, pend, s;
    logic [W-1:0] x, y;
    logic [2*W-1:0] res;
    int issued = 0, recv = 0;
    exp_q.delete();
    pend = 1'b0; s = 1'b0; x = '0; y = '0;
    for (int t = 0; t < 600 && (issued < NR || recv < issued); t++) begin
      if (!pend && issued < NR && $urandom_range(0, 3) != 0) begin
        pend = 1'b1; s = 1'($urandom()); x = rand_op(); y = rand_op();
      end
      ordy = (issued >= NR) || ($urandom_range(0, 3) != 0);
      drive_cycle(pend, s, x, y, ordy, acc, ov, res, ir);
      if (acc) begin
        exp_q.push_back(model(s, x, y));
        pend = 1'b0;
        issued++;
      end
      if (ov) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++; $display("FAIL rand_extra: got result %h expected none", res);
        end else begin
          if (res !== exp_q[0]) begin errors++; $display("FAIL rand_value[%0d]: got %h expected %h", recv, res, exp_q[0]); end
          if (ordy) begin void'(exp_q.pop_front()); recv++; end
        end
      end
    end
    checks++;
    if (recv !== NR) begin errors++; $display("FAIL rand_count: got %0d expected %0d", recv, NR); end
  endtask

  task automatic test_reset_midflight();
    logic acc, ov, ir;
    logic [2*W-1:0] res;
    for (int t = 0; t < 3; t++) begin
      drive_cycle(1'b1, 1'b0, C_ONES, C_ONES, 1'b1, acc, ov, res, ir);
    end
    rst = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL midrst_out_valid: got %b expected 0", bus.out_valid); end
    checks++;
    if ({bus.hi, bus.lo} !== '0) begin errors++; $display("FAIL midrst_hilo: got %h expected 0", {bus.hi, bus.lo}); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int t = 0; t < 12; t++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, ov, res, ir);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL midrst_stale[%0d]: got out_valid %b expected 0", t, ov); end
    end
    checks++;
    if (res !== '0) begin errors++; $display("FAIL midrst_data: got %h expected 0", res); end
  endtask

`ifdef MULT_FLUSH_EN
  task automatic test_flush();
    logic acc, ov, ir, found;
    logic [2*W-1:0] res, got;
    int lat;
    flush = 1'b0;
    drive_cycle(1'b1, 1'b1, C_MIN, C_MIN, 1'b1, acc, ov, res, ir);
    found = 1'b0; lat = 0; got = '0;
    for (int n = 1; n <= 20 && !found; n++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, ov, res, ir);
      if (ov) begin found = 1'b1; lat = n; got = res; end
    end
    checks++;
    if (lat !== LAT) begin errors++; $display("FAIL flush_ref_latency: got %0d expected %0d", lat, LAT); end
    checks++;
    if (got !== {C_MIN >> 1, {W{1'b0}}}) begin errors++; $display("FAIL flush_ref_value: got %h expected %h", got, {C_MIN >> 1, {W{1'b0}}}); end
    drive_cycle(1'b1, 1'b1, C_MIN, C_MIN, 1'b1, acc, ov, res, ir);
    flush = 1'b1;
    drive_cycle(1'b1, 1'b0, C_ONE, C_ONE, 1'b1, acc, ov, res, ir);
    flush = 1'b0;
    for (int t = 0; t < 12; t++) begin
      drive_cycle(1'b0, 1'b0, '0, '0, 1'b1, acc, ov, res, ir);
      checks++;
      if (ov !== 1'b0) begin errors++; $display("FAIL flush_killed[%0d]: got out_valid %b expected 0", t, ov); end
    end
  endtask
`endif

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_signed = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.out_ready = 1'b0;
`ifdef MULT_FLUSH_EN
    flush = 1'b0;
`endif
    test_reset();
    test_directed();
    test_back_to_back();
    test_backpressure();
    test_random();
    test_reset_midflight();
`ifdef MULT_FLUSH_EN
    test_flush();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got simulation still running expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/pipe_mult_unit.md
Name: pipe_mult_unit

Overview:
- Parametrised, fully pipelined WIDTH x WIDTH multiplier for the CPU's MULT/MULTU path. Successor to the fixed 32-bit unsigned tree multiplier.
- Adds signed/unsigned mode per operation, a valid/ready handshake with backpressure, and a {hi, lo} split result.
- Sits between the ID/EX operand latch and the HI/LO register write port. Accepts one operation per cycle when not stalled.

Parameters:
- WIDTH, 32, operand width. Must be a power of two, 4..64.
- LEVELS, $clog2(WIDTH), adder-tree depth. Derived; not overridden.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair valid
- in_ready  output  1  unit can accept an operand pair this cycle
- in_signed  input  1  1 = MULT (two's complement), 0 = MULTU
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  result valid
- out_ready  input  1  consumer accepts result
- hi  output  WIDTH  upper half of product
- lo  output  WIDTH  lower half of product
- flush  input  1  pipeline kill; present only with MULT_FLUSH_EN

Behaviour:
- Reset (rst=0, async): all pipeline data and valid bits clear. out_valid=0, hi=0, lo=0, in_ready=1.
- Global advance: adv = !out_valid | out_ready. in_ready = adv.
  - When adv=1, every stage shifts one step.
  - When adv=0, every data and valid register holds.
  - Bubbles are not compressed.
- Stage 0 (capture, on in_valid & adv):
  - Record sign flag s = in_signed & (a[W-1] ^ b[W-1]).
  - Take magnitudes |a| and |b|. Unsigned mode uses the operands as-is.
  - Form WIDTH partial products pp[i] = b_mag[i] ? (a_mag << i) : 0, each 2*WIDTH bits wide.
  - Capture of a bubble (in_valid=0 & adv) writes valid=0; its data is don't-care.
- Stages 1..LEVELS: pairwise 2*WIDTH-bit additions, halving the term count each stage. The sign flag and valid bit travel alongside.
- Final stage (LEVELS): the sum is two's-complement negated when s=1, in the same cycle. {hi, lo} = result.
- Latency: LEVELS+1 cycles from acceptance to out_valid, absent stalls (6 for WIDTH=32). Throughput is 1 op per cycle.
- Width and overflow rules:
  - The product never overflows 2*WIDTH bits.
  - Signed min*min = 2^(2W-2) is exact. |min| = 2^(W-1) fits the unsigned magnitude.
  - Zero operands with s=1 produce 0; negating 0 stays 0.
- Outputs hold stable while out_valid=1 & out_ready=0.
- Simultaneous events:
  - Output acceptance and new input in the same cycle is allowed; both advance.
  - Reset mid-operation discards all in-flight operations.
- in_valid asserted while in_ready=0: the operation is not taken. The producer must hold the operands.

Optional Feature:
- Macro: MULT_FLUSH_EN.
- Defined:
  - The flush port exists.
  - flush=1 synchronously clears every pipeline valid bit (out_valid=0 next cycle).
  - The input presented in the same cycle is discarded.
  - Data registers are untouched.
  - flush overrides stall.
- Undefined:
  - No flush port.
  - In-flight operations drain normally; only rst clears them.

Test Plan:
- Unsigned 32-bit: a=0xFFFFFFFF, b=0xFFFFFFFF, in_signed=0, out_ready=1 -> after 6 cycles out_valid=1, hi=0xFFFFFFFE, lo=0x00000001.
- Signed 32-bit: a=0xFFFFFFFF(-1), b=0x00000007, in_signed=1 -> hi=0xFFFFFFFF, lo=0xFFFFFFF9. Also a=b=0x80000000 signed -> hi=0x40000000, lo=0.
- Back-to-back: 8 consecutive ops (a=i+1, b=3, mixed modes), out_ready=1 -> 8 results on 8 consecutive cycles, in order, starting at cycle 6.
- Backpressure: hold out_ready=0 for 4 cycles with pipe full -> in_ready=0, hi/lo/out_valid frozen. Release -> no loss or duplication.
- Reset mid-flight: 3 ops issued, rst pulsed low at cycle 2 -> out_valid stays 0, hi=lo=0, no stale result emerges.
- WIDTH=8 instance, with MULT_FLUSH_EN: a=0x80, b=0x80 signed -> {hi,lo}=0x4000 after 4 cycles. Repeat with flush asserted 1 cycle after issue -> no out_valid.
